// File: rtl/adc_18s022_pkg.sv
// adc_18s022_pkg: shared constants and types for the ADC18S022 SPI responder.
// Holds frame geometry, address edge numbers, state encoding and counter widths.
`timescale 1ns/1ps
package adc_18s022_pkg;

    localparam int CH_NUM          = 8;
    localparam int DATA_W          = 12;
    localparam int FRAME_BITS      = 16;
    localparam int LEAD_ZEROS      = 4;
    localparam int ADDR_FIRST_EDGE = 3;
    localparam int ADDR_LAST_EDGE  = 5;

    localparam int CH_W   = 3;
    localparam int CNT_W  = 4;
    localparam int FCNT_W = 9;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } adc_state_e;

    // Frame word as it leaves DO: leading zeros, then the sample MSB first.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [DATA_W-1:0] sample
    );
        return {{LEAD_ZEROS{1'b0}}, sample};
    endfunction

endpackage

// File: rtl/adc_18s022_slave_if.sv
// adc_18s022_slave_if: SPI pin bundle between an ADC master and the responder.
// Signals: ADC_CS (active low), ADC_SCLK, ADC_DI toward the slave; ADC_DO, ADC_DO_oe back.
`timescale 1ns/1ps
interface adc_18s022_slave_if;

    logic ADC_CS;
    logic ADC_SCLK;
    logic ADC_DI;
    logic ADC_DO;
    logic ADC_DO_oe;

    modport master (
        output ADC_CS,
        output ADC_SCLK,
        output ADC_DI,
        input  ADC_DO,
        input  ADC_DO_oe
    );

    modport slave (
        input  ADC_CS,
        input  ADC_SCLK,
        input  ADC_DI,
        output ADC_DO,
        output ADC_DO_oe
    );

endinterface

// File: rtl/adc_18s022_slave_pin_sync.sv
// adc_pin_sync: 2-FF synchronizer for an asynchronous pin plus registered edge strobes.
// Ports: clk_i, rst_i, pin_i in; sync_o level, rise_o / fall_o one-cycle strobes out.
`timescale 1ns/1ps
module adc_pin_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Strobes are registered so an edge captured at cycle t acts at t+2
    // and its effects are visible after t+3.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adc_18s022_slave.sv
// adc_18s022_slave: emulated 8-channel 12-bit ADC18S022 SPI responder.
// Ports: Clk, Rst (async high); bus (slave modport: CS/SCLK/DI in, DO/DO_oe out);
// Ch_data 96-bit samples in; Active, Frame_done, Frame_chan, Next_chan, Frame_err out.
// Build option ADC_SLV_PATTERN_EN: samples become {channel, 9-bit frame counter}.
`timescale 1ns/1ps
module adc_18s022_slave
    import adc_18s022_pkg::*;
(
    input  logic                     Clk,
    input  logic                     Rst,
    adc_18s022_slave_if.slave        bus,
    input  logic [CH_NUM*DATA_W-1:0] Ch_data,
    output logic                     Active,
    output logic                     Frame_done,
    output logic [CH_W-1:0]          Frame_chan,
    output logic [CH_W-1:0]          Next_chan,
    output logic                     Frame_err
);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;
    logic di_sync;
    logic cs_sync_unused, sclk_sync_unused;
    logic di_rise_unused, di_fall_unused;

    adc_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .pin_i  (bus.ADC_CS),
        .sync_o (cs_sync_unused),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    adc_pin_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .pin_i  (bus.ADC_SCLK),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    adc_pin_sync #(.RST_VAL(1'b0)) u_di_sync (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .pin_i  (bus.ADC_DI),
        .sync_o (di_sync),
        .rise_o (di_rise_unused),
        .fall_o (di_fall_unused)
    );

    adc_state_e            state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      rise_cnt_q;
    logic [CNT_W-1:0]      fall_cnt_q;
    logic [1:0]            addr_q;
    logic [CH_W-1:0]       cur_chan_q;
    logic [CH_W-1:0]       frm_chan_q;
    logic [CH_W-1:0]       next_chan_q;
    logic [CH_W-1:0]       frame_chan_q;
    logic                  done_q;
    logic                  err_q;
    logic                  sess_done_q;

    logic [DATA_W-1:0]     sample_d;
    logic [FRAME_BITS-1:0] load_d;
    logic                  rise_last;
    logic                  fall_last;

    assign rise_last = sclk_rise && (rise_cnt_q == CNT_W'(FRAME_BITS-1));
    assign fall_last = sclk_fall && (fall_cnt_q == CNT_W'(FRAME_BITS-1));

`ifdef ADC_SLV_PATTERN_EN
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [FCNT_W-1:0] pat_cnt_d;
    logic [CH_NUM*DATA_W-1:0] ch_data_unused;

    assign ch_data_unused = Ch_data;

    // A reload on falling edge 16 precedes that frame's rising edge 16,
    // so it already counts the frame about to complete.
    assign pat_cnt_d = (state_q == ACTIVE) ? frame_cnt_q + FCNT_W'(1)
                                           : frame_cnt_q;
    assign sample_d  = {next_chan_q, pat_cnt_d};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            frame_cnt_q <= '0;
        end else if (state_q == ACTIVE && rise_last) begin
            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
        end
    end
`else
    assign sample_d = Ch_data[next_chan_q*DATA_W +: DATA_W];
`endif

    assign load_d = frame_word(sample_d);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            rise_cnt_q   <= '0;
            fall_cnt_q   <= '0;
            addr_q       <= '0;
            cur_chan_q   <= '0;
            frm_chan_q   <= '0;
            next_chan_q  <= '0;
            frame_chan_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            sess_done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q     <= ACTIVE;
                        shift_q     <= load_d;
                        rise_cnt_q  <= '0;
                        fall_cnt_q  <= '0;
                        addr_q      <= '0;
                        cur_chan_q  <= next_chan_q;
                        frm_chan_q  <= next_chan_q;
                        sess_done_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // CS wins over a coincident SCLK edge, except that
                        // rising edge 16 still completes the frame.
                        state_q <= IDLE;
                        shift_q <= '0;
                        if (rise_last) begin
                            done_q       <= 1'b1;
                            frame_chan_q <= frm_chan_q;
                        end else if (rise_cnt_q != '0 || !sess_done_q) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rise_cnt_q <= rise_cnt_q + CNT_W'(1);
                            if (rise_cnt_q == CNT_W'(ADDR_FIRST_EDGE-1))
                                addr_q[1] <= di_sync;
                            if (rise_cnt_q == CNT_W'(ADDR_FIRST_EDGE))
                                addr_q[0] <= di_sync;
                            if (rise_cnt_q == CNT_W'(ADDR_LAST_EDGE-1))
                                next_chan_q <= {addr_q, di_sync};
                            if (rise_last) begin
                                done_q       <= 1'b1;
                                frame_chan_q <= frm_chan_q;
                                sess_done_q  <= 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            fall_cnt_q <= fall_cnt_q + CNT_W'(1);
                            if (fall_last) begin
                                // Next frame starts here; the finishing frame's
                                // channel is kept for its rising edge 16.
                                shift_q    <= load_d;
                                cur_chan_q <= next_chan_q;
                                frm_chan_q <= cur_chan_q;
                            end else begin
                                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ADC_DO    = shift_q[FRAME_BITS-1];
    assign bus.ADC_DO_oe = (state_q == ACTIVE);
    assign Active        = (state_q == ACTIVE);
    assign Frame_done    = done_q;
    assign Frame_err     = err_q;
    assign Frame_chan    = frame_chan_q;
    assign Next_chan     = next_chan_q;

endmodule
